bus_ctl: RTL

Parametrised system-bus controller that serves N handshake requesters (MCU/SPI, video fetch, future DMA) during CPU-released bus windows. Each window carries exactly one bus transaction. The block arbitrates round-robin among requesters and drives address, R/W and write data onto the shared bus. It generates RAM OE/WE strobes and captures read data. It sits in the top level between the SPI protocol block and the timing block.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/bus_ctl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the system-bus controller.
// Ports: none (package). Provides the controller FSM state enum, default
// address/data widths and the VRAM base nibble used by the mirroring option.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } bus_state_t;

  localparam int BUS_ADDR_W = 17;
  localparam int BUS_DATA_W = 8;

  // Address nibble [15:12] of the 40-column video RAM region ($8000-$8FFF).
  localparam logic [3:0] VRAM_BASE_NIB = 4'h8;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports: req (request vector), last (index of last-served channel);
//        gnt (one-hot grant, zero when no request), gnt_idx (granted index).
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  last,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx
);

  int                cand;
  logic [NUM_CH-1:0] req_sh;
  logic              found;

  // Scan from last+1 upward with wrap; the last-served channel is visited last,
  // so it only wins again when nobody else is asking.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    req_sh  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = int'(last) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      req_sh = req >> cand;
      if (!found && req_sh[0]) begin
        found   = 1'b1;
        gnt     = NUM_CH'(1) << cand;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/bus_ctl.sv
// bus_ctl: round-robin system-bus controller, one transaction per CPU-released bus window.
// Ports: clk_sys_i/rst_ni; per-channel req_valid_i/req_rw_ni/req_addr_i/req_data_i with
//        req_ready_o completion pulse and rd_data_o; bus_window_i/bus_data_i from the bus;
//        bus address/rw/data drivers with their enables, ram_oe_o/ram_we_o strobes,
//        busy_o and overrun_o status.
// Option: define BUS_CTL_VRAM_MIRROR_EN to fold $8000-$8FFF onto the 1 KB video RAM.
module bus_ctl
  import bus_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADDR_W     = BUS_ADDR_W,
  parameter int DATA_W     = BUS_DATA_W,
  parameter int STROBE_CYC = 2
) (
  input  logic                     clk_sys_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH-1:0]        req_rw_ni,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic [DATA_W-1:0]        rd_data_o,
  input  logic                     bus_window_i,
  input  logic [DATA_W-1:0]        bus_data_i,
  output logic [ADDR_W-1:0]        bus_addr_o,
  output logic                     bus_addr_oe,
  output logic                     bus_rw_no,
  output logic                     bus_rw_noe,
  output logic [DATA_W-1:0]        bus_data_o,
  output logic                     bus_data_oe,
  output logic                     ram_oe_o,
  output logic                     ram_we_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam int         IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] LAST_STB = 4'(STROBE_CYC - 1);

  bus_state_t          state_q, state_d;
  logic                win_q, win_qq, win_rise, grant;
  logic [IDX_W-1:0]    last_q, gnt_idx;
  logic [NUM_CH-1:0]   gnt_oh, gnt_q, rw_vec;
  logic [ADDR_W-1:0]   addr_q, addr_sel, addr_out;
  logic                rw_q, rw_sel;
  logic [DATA_W-1:0]   wdat_q, wdat_sel, rd_cap, rd_q;
  logic [3:0]          cnt_q;
  logic                ovr_q;
  logic                in_xfer;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req     (req_valid_i),
    .last    (last_q),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // Window edge is taken from two registered samples; a rise that arrives
  // while a transaction is in flight is simply lost (window consumed).
  assign win_rise = win_q & ~win_qq;
  assign grant    = (state_q == ST_IDLE) && win_rise && (|req_valid_i);
  assign in_xfer  = (state_q == ST_SETUP) || (state_q == ST_STROBE) || (state_q == ST_HOLD);

  // Payload of the granted channel, selected by shifting the packed vectors.
  assign addr_sel = ADDR_W'(req_addr_i >> (int'(gnt_idx) * ADDR_W));
  assign wdat_sel = DATA_W'(req_data_i >> (int'(gnt_idx) * DATA_W));
  assign rw_vec   = req_rw_ni >> gnt_idx;
  assign rw_sel   = rw_vec[0];

  always_comb begin
    addr_out = addr_q;
`ifdef BUS_CTL_VRAM_MIRROR_EN
    // 1 KB video RAM is only partially decoded: A11:A10 are don't-care inside $8xxx.
    if (addr_q[15:12] == VRAM_BASE_NIB) addr_out[11:10] = 2'b00;
`endif
  end

  assign bus_addr_o = addr_out;
  assign bus_rw_no  = rw_q;
  assign bus_data_o = wdat_q;
  assign rd_data_o  = rd_q;

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Enables and strobes decode straight from the state register so that an
  // asynchronous reset removes them immediately.
  always_comb begin
    state_d     = state_q;
    bus_addr_oe = 1'b0;
    bus_rw_noe  = 1'b0;
    bus_data_oe = 1'b0;
    ram_oe_o    = 1'b0;
    ram_we_o    = 1'b0;
    req_ready_o = '0;
    overrun_o   = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        bus_addr_oe = 1'b1;
        bus_rw_noe  = 1'b1;
        bus_data_oe = ~rw_q;
        state_d     = ST_STROBE;
      end
      ST_STROBE: begin
        bus_addr_oe = 1'b1;
        bus_rw_noe  = 1'b1;
        bus_data_oe = ~rw_q;
        ram_oe_o    = rw_q;
        ram_we_o    = ~rw_q;
        if (cnt_q == LAST_STB) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        bus_addr_oe = 1'b1;
        bus_rw_noe  = 1'b1;
        bus_data_oe = ~rw_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        req_ready_o = gnt_q;
        overrun_o   = ovr_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q  <= 1'b0;
      win_qq <= 1'b0;
      last_q <= IDX_W'(NUM_CH - 1);
      gnt_q  <= '0;
      addr_q <= '0;
      rw_q   <= 1'b0;
      wdat_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      rd_cap <= '0;
      rd_q   <= '0;
    end else begin
      win_q  <= bus_window_i;
      win_qq <= win_q;
      if (grant) begin
        last_q <= gnt_idx;
        gnt_q  <= gnt_oh;
        addr_q <= addr_sel;
        rw_q   <= rw_sel;
        wdat_q <= wdat_sel;
        ovr_q  <= 1'b0;
      end
      if (state_q == ST_SETUP)       cnt_q <= '0;
      else if (state_q == ST_STROBE) cnt_q <= cnt_q + 4'd1;
      // Any clock of SETUP..HOLD seen without the window means the bus was
      // reclaimed early; the transfer still finishes but is flagged.
      if (in_xfer && !bus_window_i) ovr_q <= 1'b1;
      if ((state_q == ST_STROBE) && (cnt_q == LAST_STB)) rd_cap <= bus_data_i;
      if ((state_q == ST_HOLD) && rw_q) rd_q <= rd_cap;
    end
  end

endmodule
